// File: rtl/seq_calc_pkg.sv
// seq_calc_pkg: shared types and helpers for the sequential calculator engine.
//   op_t       operation codes (OP_ADD .. OP_RSVD)
//   state_t    engine FSM states
//   iter_count number of EXEC iterations an operation needs
package seq_calc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_SQRT = 3'd4,
      OP_CMP  = 3'd5,
      OP_SQR  = 3'd6,
      OP_RSVD = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_BCD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Divide by zero skips iteration entirely and is resolved in one EXEC cycle.
   function automatic int iter_count(op_t op, logic b_zero, int width);
      case (op)
         OP_MUL, OP_SQR: return width;
         OP_DIV:         return b_zero ? 0 : width;
         OP_SQRT:        return width / 2;
         default:        return 0;
      endcase
   endfunction

endpackage

// File: rtl/seq_bcd_convert.sv
// seq_bcd_convert: iterative double-dabble binary-to-BCD converter.
//   clk, rst : clock, asynchronous active-high reset (aborts a conversion)
//   start    : load bin and begin; one bit converted per cycle, BIN_W cycles
//   bin      : binary value, sampled with start
//   last     : high in the cycle whose edge completes the conversion
//   bcd      : converted value, updated on completion, held otherwise
// Only instantiated when SEQ_CALC_BCD_OUT_EN is defined.
module seq_bcd_convert #(
   parameter  int BIN_W  = 16,
   localparam int DIGITS = (BIN_W + 2) / 3,
   localparam int BCD_W  = 4 * DIGITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             last,
   output logic [BCD_W-1:0] bcd
);

   localparam int CW = $clog2(BIN_W + 1);

   logic             active_q, active_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] work_q, work_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BCD_W-1:0] adj;
   logic [BCD_W-1:0] shifted;

   always_comb begin
      adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      // top bit of the adjusted value is always zero with DIGITS sized for BIN_W
      shifted  = BCD_W'({adj, bin_q[BIN_W-1]});
      last     = active_q && (cnt_q == CW'(1));

      active_d = active_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      work_d   = work_q;
      bcd_d    = bcd_q;
      if (start) begin
         active_d = 1'b1;
         cnt_d    = CW'(BIN_W);
         bin_d    = bin;
         work_d   = '0;
      end else if (active_q) begin
         work_d = shifted;
         bin_d  = bin_q << 1;
         cnt_d  = cnt_q - 1'b1;
         if (last) begin
            active_d = 1'b0;
            bcd_d    = shifted;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         bin_q    <= '0;
         work_q   <= '0;
         bcd_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         work_q   <= work_d;
         bcd_q    <= bcd_d;
      end
   end

   assign bcd = bcd_q;

endmodule

// File: rtl/seq_calc_engine.sv
// seq_calc_engine: start/busy/done arithmetic engine (ADD, SUB, MUL, DIV, SQRT,
// CMP, SQR). MUL/SQR shift-add, DIV restoring, SQRT digit-by-digit, one step
// per cycle; the rest resolve in a single EXEC cycle.
//   clk, rst       : clock, asynchronous active-high reset
//   start, op, a, b: request and operands, sampled only in IDLE
//   busy, done     : busy during EXEC (and BCD), done one-cycle pulse
//   result, remainder, carry, dbz, op_err : held until the next completion
//   bcd            : BCD of result, present only with SEQ_CALC_BCD_OUT_EN
//
// state  | meaning
// S_IDLE | waiting for start
// S_EXEC | iterating; final cycle (cnt 0) registers the outputs
// S_BCD  | converting result to BCD (SEQ_CALC_BCD_OUT_EN only)
// S_DONE | done pulse, back to IDLE
module seq_calc_engine
   import seq_calc_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int RES_W = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             carry,
   output logic             dbz,
`ifdef SEQ_CALC_BCD_OUT_EN
   output logic [4*((RES_W+2)/3)-1:0] bcd,
`endif
   output logic             op_err
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   op_t              op_q, op_d, op_in;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RES_W-1:0] mc_q, mc_d, acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d, rem_q, rem_d, root_q, root_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [RES_W-1:0] result_q, result_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             carry_q, carry_d, dbz_q, dbz_d, op_err_q, op_err_d;

   logic [WIDTH:0]   add_w, div_sh;
   logic [WIDTH-1:0] sub_w;
   logic [WIDTH+1:0] sq_r, sq_t;
   logic             div_ge, sq_ge;

`ifdef SEQ_CALC_BCD_OUT_EN
   logic conv_start, conv_last;

   seq_bcd_convert #(.BIN_W(RES_W)) u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (result_d),
      .last  (conv_last),
      .bcd   (bcd)
   );
`endif

   always_comb begin
      op_in  = op_t'(op);
      add_w  = {1'b0, a_q} + {1'b0, b_q};
      sub_w  = a_q - b_q;
      // restoring division: shift next dividend bit (y_q MSB) into the remainder
      div_sh = {rem_q, y_q[WIDTH-1]};
      div_ge = div_sh >= {1'b0, b_q};
      // square root: bring down two operand bits, trial subtract 4*root+1
      sq_r   = {rem_q, y_q[WIDTH-1:WIDTH-2]};
      sq_t   = {root_q, 2'b01};
      sq_ge  = sq_r >= sq_t;

      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      mc_d        = mc_q;
      acc_d       = acc_q;
      y_d         = y_q;
      rem_d       = rem_q;
      root_d      = root_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      carry_d     = carry_q;
      dbz_d       = dbz_q;
      op_err_d    = op_err_q;
`ifdef SEQ_CALC_BCD_OUT_EN
      conv_start  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op_in;
               a_d     = a;
               b_d     = b;
               cnt_d   = CW'(iter_count(op_in, (b == '0), WIDTH));
               mc_d    = RES_W'(a);
               acc_d   = '0;
               y_d     = (op_in == OP_MUL) ? b : a;
               rem_d   = '0;
               root_d  = '0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               case (op_q)
                  OP_MUL, OP_SQR: begin
                     if (y_q[0]) acc_d = acc_q + mc_q;
                     mc_d = mc_q << 1;
                     y_d  = y_q >> 1;
                  end
                  OP_DIV: begin
                     rem_d = div_ge ? WIDTH'(div_sh - {1'b0, b_q}) : div_sh[WIDTH-1:0];
                     y_d   = {y_q[WIDTH-2:0], div_ge};
                  end
                  OP_SQRT: begin
                     rem_d  = sq_ge ? WIDTH'(sq_r - sq_t) : sq_r[WIDTH-1:0];
                     root_d = {root_q[WIDTH-2:0], sq_ge};
                     y_d    = y_q << 2;
                  end
                  default: ;
               endcase
            end else begin
               result_d    = '0;
               remainder_d = '0;
               carry_d     = 1'b0;
               dbz_d       = 1'b0;
               op_err_d    = 1'b0;
               case (op_q)
                  OP_ADD: begin
                     result_d = RES_W'(add_w);
                     carry_d  = add_w[WIDTH];
                  end
                  OP_SUB: begin
                     result_d = RES_W'(sub_w);
                     carry_d  = a_q < b_q;
                  end
                  OP_MUL, OP_SQR: result_d = acc_q;
                  OP_DIV: begin
                     if (b_q == '0) begin
                        result_d    = RES_W'({WIDTH{1'b1}});
                        remainder_d = a_q;
                        dbz_d       = 1'b1;
                     end else begin
                        result_d    = RES_W'(y_q);
                        remainder_d = rem_q;
                     end
                  end
                  OP_SQRT: begin
                     result_d    = RES_W'(root_q);
                     remainder_d = rem_q;
                  end
                  OP_CMP:  result_d = RES_W'({a_q > b_q, a_q == b_q, a_q < b_q});
                  default: op_err_d = 1'b1;
               endcase
`ifdef SEQ_CALC_BCD_OUT_EN
               conv_start = 1'b1;
               state_d    = S_BCD;
`else
               state_d    = S_DONE;
`endif
            end
         end
`ifdef SEQ_CALC_BCD_OUT_EN
         S_BCD: begin
            if (conv_last) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_EXEC) || (state_d == S_BCD);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_ADD;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         mc_q        <= '0;
         acc_q       <= '0;
         y_q         <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         carry_q     <= 1'b0;
         dbz_q       <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         mc_q        <= mc_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         carry_q     <= carry_d;
         dbz_q       <= dbz_d;
         op_err_q    <= op_err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign remainder = remainder_q;
   assign carry     = carry_q;
   assign dbz       = dbz_q;
   assign op_err    = op_err_q;

endmodule
